// File: rtl/cpu_pkg.sv
// Shared types for the CPU control unit: opcodes, ALU operation codes,
// sequencer states and the decoded-control bundle.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_ADDI = 4'd5,
    OP_LD   = 4'd6,
    OP_ST   = 4'd7,
    OP_JMP  = 4'd8,
    OP_NOP  = 4'd14,
    OP_HALT = 4'd15
  } op_e;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd4;
  localparam logic [2:0] ALU_LD   = 3'd5;
  localparam logic [2:0] ALU_ST   = 3'd6;
  localparam logic [2:0] ALU_PASS = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WAIT_DONE,
    S_WB,
    S_HALTED
  } state_e;

  typedef struct packed {
    logic [2:0] rf_wr_sel;
    logic [2:0] reg_1_sel;
    logic [2:0] reg_2_sel;
    logic       R1_sel;
    logic       R2_sel;
    logic       PC_sel;
    logic       rf_write_sel;
    logic       write_rf_bool;
    logic [2:0] ALU_sel;
    logic       illegal;
    logic       halt;
  } ctrl_t;

  // Register fields always pass straight through; everything else starts as a NOP.
  function automatic ctrl_t nop_ctrl(input logic [8:0] regs);
    ctrl_t c;
    c.rf_wr_sel     = regs[8:6];
    c.reg_1_sel     = regs[5:3];
    c.reg_2_sel     = regs[2:0];
    c.R1_sel        = 1'b0;
    c.R2_sel        = 1'b0;
    c.PC_sel        = 1'b0;
    c.rf_write_sel  = 1'b1;
    c.write_rf_bool = 1'b0;
    c.ALU_sel       = ALU_PASS;
    c.illegal       = 1'b0;
    c.halt          = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/cpu_control_unit_if.sv
// Instruction-memory request/valid handshake between the control unit
// (master) and the instruction memory (slave).
interface cpu_control_unit_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_valid;
  logic [15:0] imem_data;

  modport master (output imem_req, imem_addr, input imem_valid, imem_data);
  modport slave  (input imem_req, imem_addr, output imem_valid, imem_data);
endinterface

// File: rtl/cpu_decoder.sv
// Combinational instruction decoder: IR in, datapath control bundle out.
module cpu_decoder
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  output ctrl_t       ctrl
);

  // Low three bits carry no control information in this encoding.
  logic [2:0] unused_ir_lsb;
  assign unused_ir_lsb = ir[2:0];

  always_comb begin
    ctrl = nop_ctrl(ir[11:3]);
    case (ir[15:12])
      OP_ADD:  begin ctrl.ALU_sel = ALU_ADD; ctrl.write_rf_bool = 1'b1; end
      OP_SUB:  begin ctrl.ALU_sel = ALU_SUB; ctrl.write_rf_bool = 1'b1; end
      OP_AND:  begin ctrl.ALU_sel = ALU_AND; ctrl.write_rf_bool = 1'b1; end
      OP_OR:   begin ctrl.ALU_sel = ALU_OR;  ctrl.write_rf_bool = 1'b1; end
      OP_XOR:  begin ctrl.ALU_sel = ALU_XOR; ctrl.write_rf_bool = 1'b1; end
      OP_ADDI: begin
        ctrl.ALU_sel       = ALU_ADD;
        ctrl.R2_sel        = 1'b1;
        ctrl.write_rf_bool = 1'b1;
      end
      OP_LD: begin
        ctrl.ALU_sel       = ALU_LD;
        ctrl.R2_sel        = 1'b1;
        ctrl.rf_write_sel  = 1'b0;
        ctrl.write_rf_bool = 1'b1;
      end
      OP_ST: begin
        ctrl.ALU_sel = ALU_ST;
        ctrl.R2_sel  = 1'b1;
      end
      OP_JMP: begin
        ctrl.ALU_sel = ALU_ADD;
        ctrl.R1_sel  = 1'b1;
        ctrl.R2_sel  = 1'b1;
        ctrl.PC_sel  = 1'b1;
      end
      OP_NOP:  ctrl.illegal = 1'b0;
      OP_HALT: ctrl.halt    = 1'b1;
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Sequencing controller for cpu_data_path: fetch, decode, execute strobe,
// completion wait with timeout, and PC/instruction-count writeback.
module cpu_control_unit
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter int          DONE_TIMEOUT = 64,
  parameter int          CNT_W        = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  cpu_control_unit_if.master imem,
  output logic [15:0]        IR,
  output logic [15:0]        PC,
  input  logic [15:0]        PC_out,
  input  logic               next_IR,
  output logic [2:0]         rf_wr_sel,
  output logic [2:0]         reg_1_sel,
  output logic [2:0]         reg_2_sel,
  output logic               R1_sel,
  output logic               R2_sel,
  output logic               PC_sel,
  output logic               rf_write_sel,
  output logic               write_rf_bool,
  output logic [2:0]         ALU_sel,
  output logic               begin_instruction,
  output logic               halted,
  output logic               illegal_instr,
  output logic               timeout_err,
  output logic [CNT_W-1:0]   instr_count
);

  localparam int TW = (DONE_TIMEOUT > 2) ? $clog2(DONE_TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(DONE_TIMEOUT - 1);

  state_e        state;
  logic [TW-1:0] timer;
  ctrl_t         dec;

  cpu_decoder u_dec (
    .ir   (IR),
    .ctrl (dec)
  );

  assign imem.imem_addr = PC;

  // IR has no reset: it only ever loads from a completed fetch.
  always_ff @(posedge clk) begin
    if (state == S_FETCH && imem.imem_valid) IR <= imem.imem_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= S_IDLE;
      PC                <= RESET_PC;
      timer             <= '0;
      imem.imem_req     <= 1'b0;
      begin_instruction <= 1'b0;
      rf_wr_sel         <= '0;
      reg_1_sel         <= '0;
      reg_2_sel         <= '0;
      R1_sel            <= 1'b0;
      R2_sel            <= 1'b0;
      PC_sel            <= 1'b0;
      rf_write_sel      <= 1'b0;
      write_rf_bool     <= 1'b0;
      ALU_sel           <= '0;
      halted            <= 1'b0;
      illegal_instr     <= 1'b0;
      timeout_err       <= 1'b0;
      instr_count       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (run && !halted) begin
            state         <= S_FETCH;
            imem.imem_req <= 1'b1;
          end
        end
        S_FETCH: begin
          if (imem.imem_valid) begin
            state         <= S_DECODE;
            imem.imem_req <= 1'b0;
          end
        end
        S_DECODE: begin
          // The only place the datapath selects change.
          rf_wr_sel     <= dec.rf_wr_sel;
          reg_1_sel     <= dec.reg_1_sel;
          reg_2_sel     <= dec.reg_2_sel;
          R1_sel        <= dec.R1_sel;
          R2_sel        <= dec.R2_sel;
          PC_sel        <= dec.PC_sel;
          rf_write_sel  <= dec.rf_write_sel;
          write_rf_bool <= dec.write_rf_bool;
          ALU_sel       <= dec.ALU_sel;
          if (dec.illegal) illegal_instr <= 1'b1;
          if (dec.halt) begin
            state       <= S_HALTED;
            halted      <= 1'b1;
            instr_count <= instr_count + CNT_W'(1);
          end else begin
            state             <= S_EXEC;
            begin_instruction <= 1'b1;
          end
        end
        S_EXEC: begin
          begin_instruction <= 1'b0;
          timer             <= '0;
          state             <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          // First cycle is a settle cycle; next_IR may still be stale from the datapath.
          if (timer != '0 && next_IR) begin
            state <= S_WB;
          end else if (timer == T_LAST) begin
            timeout_err <= 1'b1;
            halted      <= 1'b1;
            state       <= S_HALTED;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_WB: begin
          PC          <= PC_out;
          instr_count <= instr_count + CNT_W'(1);
          if (run) begin
            state         <= S_FETCH;
            imem.imem_req <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        S_HALTED: halted <= 1'b1;
        default:  state  <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/cpu_control_unit.md
Name: cpu_control_unit

Overview:
- Sequencing controller for `cpu_data_path`. Fetches 16-bit instructions over a simple request/valid instruction-memory handshake and latches them into IR.
- Decodes each instruction into the datapath mux and ALU selects, launches execution with `begin_instruction`, waits for `next_IR`, then commits `PC_out` back into the PC register.
- Sits directly above the datapath in the CPU top level. It owns the architectural PC and IR.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- DONE_TIMEOUT, 64, maximum cycles spent in WAIT_DONE before timeout_err is raised; minimum 2.
- CNT_W, 16, width of instr_count.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- run  in  1  level; while high the unit keeps fetching, while low it parks in IDLE after the current instruction
- imem_req  out  1  instruction fetch request, held high until imem_valid
- imem_addr  out  16  fetch address (= PC)
- imem_valid  in  1  fetch data valid
- imem_data  in  16  fetched instruction
- IR  out  16  current instruction to datapath
- PC  out  16  current PC to datapath
- PC_out  in  16  next PC from datapath
- next_IR  in  1  datapath completion flag
- rf_wr_sel, reg_1_sel, reg_2_sel  out  3 each  register file selects
- R1_sel, R2_sel, PC_sel, rf_write_sel, write_rf_bool  out  1 each  datapath mux/write controls
- ALU_sel  out  3  ALU operation
- begin_instruction  out  1  one-cycle execute strobe
- halted  out  1  sticky, HALT retired
- illegal_instr  out  1  sticky, undefined opcode seen
- timeout_err  out  1  sticky, WAIT_DONE timeout
- instr_count  out  CNT_W  retired instruction count

Behaviour:
- **Reset** (asynchronous, active-high) forces the following. Nothing else is reset; IR retains its previous value.
  - State goes to IDLE; PC=RESET_PC.
  - All control outputs are 0, including imem_req and begin_instruction.
  - Sticky flags and instr_count are 0.
  - Reset mid-operation abandons the instruction: no PC or count update, and an imem response already in flight is ignored.
- **Encoding:** op=IR[15:12], rd=IR[11:9], rs1=IR[8:6], rs2=IR[5:3]. Decoded fields map directly: rf_wr_sel=rd, reg_1_sel=rs1, reg_2_sel=rs2.
- **Opcode table** (ALU_sel, R1/R2/PC/rf_write_sel, write_rf_bool):
  - 0 ADD (0, 0/0/0/1, 1)
  - 1 SUB (1, 0/0/0/1, 1)
  - 2 AND (2, 0/0/0/1, 1)
  - 3 OR (3, 0/0/0/1, 1)
  - 4 XOR (4, 0/0/0/1, 1)
  - 5 ADDI (0, 0/1/0/1, 1)
  - 6 LD (5, 0/1/0/0, 1)
  - 7 ST (6, 0/1/0/1, 0)
  - 8 JMP (0, 1/1/1/1, 0)
  - 14 NOP (7, 0/0/0/1, 0)
  - 15 HALT
  - 9–13 are undefined: decode as NOP and set illegal_instr.
- **State machine** (registered Moore outputs):
  - IDLE: imem_req=0; go to FETCH when run=1 and halted=0.
  - FETCH: imem_req=1, imem_addr=PC. On the edge where imem_valid=1: IR<=imem_data, go to DECODE. Wait indefinitely otherwise.
  - DECODE: one cycle; control outputs are registered from IR. HALT goes to HALTED (PC unchanged, count+1); everything else goes to EXEC.
  - EXEC: begin_instruction=1 for exactly this cycle; go to WAIT_DONE.
  - WAIT_DONE: next_IR is ignored in the first cycle (settle). From the second cycle on, next_IR=1 goes to WB.
    - Timer counts from 0; at count DONE_TIMEOUT-1 without next_IR, set timeout_err and go to HALTED.
  - WB: PC<=PC_out, instr_count<=instr_count+1 (wraps modulo 2^CNT_W). Go to FETCH if run=1, otherwise IDLE.
  - HALTED: halted=1; stays here until reset. run is ignored.
- **Output stability:** control selects stay stable from the cycle after DECODE through WB and change only in DECODE.
- **Fetch pacing:** minimum instruction period is 6 cycles (FETCH with same-cycle valid, DECODE, EXEC, 2×WAIT_DONE, WB).
- **Clearing:** sticky flags clear only on reset.

Decomposition:
- **cpu_pkg:**
  - opcode enum (OP_ADD … OP_HALT)
  - ALU_sel constants (ALU_ADD=0 … ALU_PASS=7)
  - state enum
  - decoded-control struct {rf_wr_sel, reg_1_sel, reg_2_sel, R1_sel, R2_sel, PC_sel, rf_write_sel, write_rf_bool, ALU_sel, illegal, halt}
- **cpu_decoder:** purely combinational sub-module, IR in, control struct out. The FSM registers its output in DECODE.

Test Plan:
- Reset with RESET_PC=16'h0010, run=1; imem_data=16'h0298 (ADD r1,r2,r3) → fetch addr 0x0010.
  - Expect begin_instruction one cycle after DECODE, with ALU_sel=0, rf_wr_sel=1, reg_1_sel=2, reg_2_sel=3, write_rf_bool=1.
  - Drive next_IR=1 with PC_out=0x0011 → PC=0x0011, instr_count=1.
- JMP 16'h8000 with PC_out=0x0040 returned → R1_sel=1, R2_sel=1, PC_sel=1, write_rf_bool=0; next imem_addr=0x0040.
- Opcode 16'hB000 → illegal_instr=1, NOP controls; execution continues; flag still set after two more instructions.
- HALT 16'hF000 → halted=1, imem_req stays 0 for 20 cycles with run=1, instr_count incremented, PC unchanged.
- Hold next_IR=0 after EXEC → timeout_err=1 after exactly DONE_TIMEOUT cycles in WAIT_DONE, then halted=1.
- Assert reset during WAIT_DONE and drop run → PC=RESET_PC, count=0, all flags 0 immediately (asynchronous), imem_req=0 until run=1.
